instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
- Registered, parametrised successor to the combinational instruction decoder. Sits between the instruction source and the register file/ALU issue logic.
- Decodes both instruction types:
  - type 0 (register-register ALU ops and ShowR)
  - type 1 (load-immediate into register)
- Flags illegal encodings.
- Valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction.

Parameters:
- INSTR_W, 16: instruction width in bits.
- REG_AW, 3: register address width. Field constraint: INSTR_W-1-2*REG_AW >= 5.
- IMM_W, INSTR_W-1-REG_AW (derived, localparam): immediate width for type 1.
- CNT_W, 8: illegal counter width; used only with DEC_ILLEGAL_CNT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept instruction
- instr  in  INSTR_W  instruction word
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- alu_op  out  5  ALU operation code
- addr1  out  REG_AW  destination/first source register
- addr2  out  REG_AW  second source register
- imm  out  IMM_W  immediate, zero-extended field
- imm_sel  out  1  1 = ALU B operand is imm
- show  out  1  display register addr1 (ShowR)
- write  out  1  register-file write enable
- illegal  out  1  undecodable instruction
- illegal_cnt  out  CNT_W  present only with DEC_ILLEGAL_CNT_EN

Behaviour:
- Decode is combinational on instr; results are registered. Latency is 1 cycle from accept to out_valid when the output stage is empty or draining.

Type 0 (instr[INSTR_W-1]==0):
- Fields:
  - addr2 = instr[REG_AW-1:0]
  - addr1 = instr[2*REG_AW-1:REG_AW]
  - opcode = instr[INSTR_W-2:2*REG_AW]
  - imm = 0, imm_sel = 0
- opcode 1..14: alu_op = opcode[4:0], write = 1, show = 0. Ops in order: ADD, AND, SUB, OR, XOR, MOV, ADC, NOT, SAR, SLR, SAL, SLL, ROL, ROR.
- opcode 18 (ShowR): alu_op = 5'b11111, show = 1, write = 0.
- Any other opcode: illegal = 1, alu_op = 0, write = 0, show = 0. Addresses still pass through.

Type 1 (instr[INSTR_W-1]==1), load-immediate:
- addr1 = instr[INSTR_W-2:IMM_W]
- imm = instr[IMM_W-1:0]
- addr2 = 0
- alu_op = 5'b00110 (MOV), imm_sel = 1, write = 1, show = 0, illegal = 0

Handshake:
- Transfer on the input side when in_valid & in_ready. Transfer on the output side when out_valid & out_ready.
- in_ready = !skid_valid, taken straight from a register with no combinational path from out_ready.
- Output register loads when !out_valid | out_ready:
  - source is the skid entry if skid_valid, else the incoming decode if accepted.
  - if neither is available, out_valid clears on drain.
- Accept while out_valid & !out_ready: the decoded bundle goes into the skid; skid_valid = 1.
- Skid drains into the output register on the next output transfer. Order is strictly preserved.
- out_valid holds with stable fields until accepted. Fields are don't-care-free: all outputs are 0 when out_valid = 0 after reset.
- Simultaneous accept + drain with skid empty: the new bundle goes straight to the output register, giving back-to-back throughput of 1 per cycle.
- Skid full: in_ready = 0; instr is ignored regardless of in_valid.

Reset:
- Asynchronously clears out_valid, skid_valid, all output fields and illegal_cnt.
- in_ready = 0 while rst is high and 1 on the first cycle after release.
- Reset mid-transfer discards both entries with no partial output.

Optional Feature:
- Macro DEC_ILLEGAL_CNT_EN.
- Defined:
  - illegal_cnt port exists.
  - Increments by 1 on each output transfer with illegal = 1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then instr = 16'h0053, in_valid = 1, out_ready = 1 -> next cycle out_valid = 1, alu_op = 5'b00001, addr1 = 2, addr2 = 3, write = 1, show = 0, imm_sel = 0.
- instr = 16'h0488 -> alu_op = 5'b11111, show = 1, write = 0, addr1 = 1.
- instr = 16'hA5FF -> alu_op = 5'b00110, imm_sel = 1, addr1 = 2, imm = 12'h5FF, write = 1.
- instr = 16'h03C0 (opcode 15) -> illegal = 1, write = 0, show = 0. With DEC_ILLEGAL_CNT_EN and CNT_W = 2, send 5 illegal instructions -> illegal_cnt = 3.
- out_ready = 0, stream 3 instructions -> two accepted, in_ready = 0 on the third. Raise out_ready -> all three emerge in order on consecutive cycles with none lost or duplicated.
- Assert rst while the skid is full -> out_valid = 0 and in_ready = 0 immediately. After release: in_ready = 1, no stale outputs.

Source files
------------

// File: rtl/instr_decode_stage.sv
// Registered instruction decoder with valid/ready handshake and a 2-entry skid buffer.
// Optional saturating illegal-instruction counter enabled by DEC_ILLEGAL_CNT_EN.
module instr_decode_stage #(
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 3
`ifdef DEC_ILLEGAL_CNT_EN
  ,
  parameter int CNT_W   = 8
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTR_W-1:0]            instr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4:0]                    alu_op,
  output logic [REG_AW-1:0]             addr1,
  output logic [REG_AW-1:0]             addr2,
  output logic [INSTR_W-1-REG_AW-1:0]   imm,
  output logic                          imm_sel,
  output logic                          show,
  output logic                          write,
`ifdef DEC_ILLEGAL_CNT_EN
  output logic [CNT_W-1:0]              illegal_cnt,
`endif
  output logic                          illegal
);

  localparam int IMM_W = INSTR_W - 1 - REG_AW;
  localparam int OPC_W = INSTR_W - 1 - 2 * REG_AW;

  typedef struct packed {
    logic [4:0]        alu_op;
    logic [REG_AW-1:0] addr1;
    logic [REG_AW-1:0] addr2;
    logic [IMM_W-1:0]  imm;
    logic              imm_sel;
    logic              show;
    logic              write;
    logic              illegal;
  } bundle_t;

  bundle_t           dec;
  bundle_t           out_q, out_d;
  bundle_t           skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              ready_q, ready_d;
  logic [OPC_W-1:0]  opcode;
  logic              accept;
  logic              out_load;
  logic              out_fire;

  assign opcode   = instr[INSTR_W-2:2*REG_AW];
  assign accept   = in_valid & ready_q;
  assign out_load = ~out_valid_q | out_ready;
  assign out_fire = out_valid_q & out_ready;

  // Combinational decode of the incoming instruction word
  always_comb begin
    dec = '0;
    if (instr[INSTR_W-1] == 1'b0) begin
      dec.addr2 = instr[REG_AW-1:0];
      dec.addr1 = instr[2*REG_AW-1:REG_AW];
      if ((opcode >= OPC_W'(1)) && (opcode <= OPC_W'(14))) begin
        dec.alu_op = opcode[4:0];
        dec.write  = 1'b1;
      end else if (opcode == OPC_W'(18)) begin
        dec.alu_op = 5'b11111;
        dec.show   = 1'b1;
      end else begin
        dec.illegal = 1'b1;
      end
    end else begin
      dec.addr1   = instr[INSTR_W-2:IMM_W];
      dec.imm     = instr[IMM_W-1:0];
      dec.alu_op  = 5'b00110;
      dec.imm_sel = 1'b1;
      dec.write   = 1'b1;
    end
  end

  // Output register / skid steering; skid always drains before new input
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_load) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_d       = '0;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_d       = '0;
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid_q;
    end
    ready_d = ~skid_valid_d;
  end

  // Pipeline state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

`ifdef DEC_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of illegal bundles handed downstream
  always_comb begin
    if (out_fire && out_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Illegal counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign illegal_cnt = cnt_q;
`else
  logic unused_fire;
  assign unused_fire = out_fire;
`endif

  assign in_ready  = ready_q;
  assign out_valid = out_valid_q;
  assign alu_op    = out_q.alu_op;
  assign addr1     = out_q.addr1;
  assign addr2     = out_q.addr2;
  assign imm       = out_q.imm;
  assign imm_sel   = out_q.imm_sel;
  assign show      = out_q.show;
  assign write     = out_q.write;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: occupancy/queue model checked every cycle plus literal pins.
module tb_instr_decode_stage;
  localparam int INSTR_W = 16;
  localparam int REG_AW  = 3;
  localparam int IMM_W   = INSTR_W - 1 - REG_AW;
`ifdef DEC_ILLEGAL_CNT_EN
  localparam int CNT_W   = 2;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic               out_valid;
  logic               out_ready;
  logic [4:0]         alu_op;
  logic [REG_AW-1:0]  addr1;
  logic [REG_AW-1:0]  addr2;
  logic [IMM_W-1:0]   imm;
  logic               imm_sel;
  logic               show;
  logic               write;
  logic               illegal;
`ifdef DEC_ILLEGAL_CNT_EN
  logic [CNT_W-1:0]   illegal_cnt;
`endif

  always #5 clk = ~clk;

  instr_decode_stage #(
    .INSTR_W(INSTR_W),
`ifdef DEC_ILLEGAL_CNT_EN
    .CNT_W(CNT_W),
`endif
    .REG_AW(REG_AW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .addr1(addr1),
    .addr2(addr2), .imm(imm), .imm_sel(imm_sel), .show(show), .write(write),
`ifdef DEC_ILLEGAL_CNT_EN
    .illegal_cnt(illegal_cnt),
`endif
    .illegal(illegal)
  );

  typedef struct {
    int alu; int a1; int a2; int im; int isel; int shw; int wr; int ill;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   rdy    = 1'b0;
  int   cnt_m  = 0;

  // Decode from the field rules, using plain integer arithmetic
  function automatic exp_t model_dec(input int w);
    exp_t e;
    int   op;
    e = '{0, 0, 0, 0, 0, 0, 0, 0};
    if (w >= 32768) begin
      e.a1   = (w / 4096) % 8;
      e.im   = w % 4096;
      e.alu  = 6;
      e.isel = 1;
      e.wr   = 1;
    end else begin
      op   = w / 64;
      e.a1 = (w / 8) % 8;
      e.a2 = w % 8;
      if (op >= 1 && op <= 14) begin
        e.alu = op;
        e.wr  = 1;
      end else if (op == 18) begin
        e.alu = 31;
        e.shw = 1;
      end else begin
        e.ill = 1;
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in-flight bundles in order; at most two (output + skid)
  always @(posedge clk) begin
    bit do_pop;
    bit do_push;
    if (rst) begin
      q.delete();
      rdy   <= 1'b0;
      cnt_m <= 0;
    end else begin
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && rdy && (q.size() < 2);
`ifdef DEC_ILLEGAL_CNT_EN
      if (do_pop && q[0].ill == 1 && cnt_m < (1 << CNT_W) - 1) cnt_m <= cnt_m + 1;
`endif
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(model_dec(int'(instr)));
      rdy <= 1'b1;
    end
  end

  // Compare DUT against model on every falling edge
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_alu_op", int'(alu_op), 0);
      check("rst_write", int'(write), 0);
    end else begin
      check("in_ready", int'(in_ready), (rdy && q.size() < 2) ? 1 : 0);
      check("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) begin
        check("alu_op", int'(alu_op), q[0].alu);
        check("addr1", int'(addr1), q[0].a1);
        check("addr2", int'(addr2), q[0].a2);
        check("imm", int'(imm), q[0].im);
        check("imm_sel", int'(imm_sel), q[0].isel);
        check("show", int'(show), q[0].shw);
        check("write", int'(write), q[0].wr);
        check("illegal", int'(illegal), q[0].ill);
      end else begin
        check("idle_fields", int'({alu_op, addr1, addr2, imm, imm_sel, show, write, illegal}), 0);
      end
`ifdef DEC_ILLEGAL_CNT_EN
      check("illegal_cnt", int'(illegal_cnt), cnt_m);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_one(input logic [INSTR_W-1:0] w);
    instr    = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [INSTR_W-1:0] stream [6] = '{16'h0053, 16'h1FFF, 16'h8000, 16'h0335, 16'h0488, 16'h4D2A};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instr = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    send_one(16'h0053);
    @(negedge clk);
    check("lit_add_valid", int'(out_valid), 1);
    check("lit_add_alu", int'(alu_op), 1);
    check("lit_add_a1", int'(addr1), 2);
    check("lit_add_a2", int'(addr2), 3);
    check("lit_add_wr_sh_is", int'({write, show, imm_sel}), 4);
    tick();

    send_one(16'h0488);
    @(negedge clk);
    check("lit_show_alu", int'(alu_op), 31);
    check("lit_show_flags", int'({show, write}), 2);
    check("lit_show_a1", int'(addr1), 1);
    tick();

    send_one(16'hA5FF);
    @(negedge clk);
    check("lit_li_alu", int'(alu_op), 6);
    check("lit_li_isel", int'(imm_sel), 1);
    check("lit_li_a1", int'(addr1), 2);
    check("lit_li_imm", int'(imm), 12'h5FF);
    check("lit_li_wr", int'(write), 1);
    tick();

    send_one(16'h03C0);
    @(negedge clk);
    check("lit_ill", int'({illegal, write, show}), 4);
    tick();

    for (int i = 0; i < 5; i++) begin
      instr    = (i % 2 == 0) ? 16'h7FC0 : 16'h0000;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
`ifdef DEC_ILLEGAL_CNT_EN
    @(negedge clk);
    check("lit_cnt_sat", int'(illegal_cnt), 3);
`endif

    for (int i = 0; i < 6; i++) begin
      instr    = stream[i];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();

    out_ready = 1'b0;
    instr = 16'h0053; in_valid = 1'b1; tick();
    instr = 16'h0093; tick();
    @(negedge clk);
    check("lit_skid_full_ready", int'(in_ready), 0);
    instr = 16'h00D3; tick();
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("lit_drain_b", int'(alu_op), 2);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_drain_c", int'(alu_op), 3);
    tick();
    tick();

    out_ready = 1'b0;
    instr = 16'h0111; in_valid = 1'b1; tick();
    instr = 16'h8123; tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("lit_rst_out_valid", int'(out_valid), 0);
    check("lit_rst_in_ready", int'(in_ready), 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("lit_post_rst_ready", int'(in_ready), 1);
    check("lit_post_rst_valid", int'(out_valid), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
